// File: rtl/eth_pkg.sv
//------------------------------------------------------------------------------
// eth_pkg -- shared Ethernet framing constants, receiver states, CRC-32 step. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package eth_pkg;

   localparam int          MAC_BYTES = 6;
   localparam int          HDR_BYTES = 12;
   localparam int          FCS_BYTES = 4;
   localparam int          MAX_FRAME = 1518;
   localparam int          MIN_FRAME = 16;
   localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;
   localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_HDR     = 2'd1,
      S_PAYLOAD = 2'd2,
      S_DROP    = 2'd3
   } rx_state_t;

   // Non-reflected, MSB-first, no final inversion; the transmitter uses the same step.
   function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                              input logic [7:0]  data,
                                              input logic [31:0] poly);
      logic [31:0] c;
      c = crc ^ {data, 24'h0};
      for (int i = 0; i < 8; i++) begin
         c = c[31] ? ((c << 1) ^ poly) : (c << 1);
      end
      return c;
   endfunction

endpackage

`default_nettype wire

// File: rtl/eth_crc32_byte.sv
//------------------------------------------------------------------------------
// eth_crc32_byte -- combinational next CRC-32 from current register and one byte. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module eth_crc32_byte #(
   parameter logic [31:0] CRC_POLY = eth_pkg::CRC_POLY
) (
   input  logic [31:0] crc_in,
   input  logic [7:0]  data_in,
   output logic [31:0] crc_out
);
   import eth_pkg::*;

   always_comb begin
      crc_out = crc32_byte(crc_in, data_in, CRC_POLY);
   end

endmodule

`default_nettype wire

// File: rtl/ethernet_rx.sv
//------------------------------------------------------------------------------
// ethernet_rx -- byte-wide Ethernet receiver: MAC capture/filter, FCS check and strip. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ethernet_rx #(
   parameter int          MAX_FRAME = eth_pkg::MAX_FRAME,
   parameter int          MIN_FRAME = eth_pkg::MIN_FRAME,
   parameter logic [31:0] CRC_POLY  = eth_pkg::CRC_POLY
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data_in,
   input  logic        rx_data_valid,
   input  logic        rx_last,
   input  logic [47:0] my_mac,
   input  logic        promisc,
   output logic [7:0]  rx_data_out,
   output logic        rx_data_out_valid,
   output logic [47:0] dest_mac_out,
   output logic [47:0] src_mac_out,
   output logic [10:0] rx_payload_len,
   output logic        rx_done,
   output logic        rx_crc_err,
   output logic        rx_len_err,
   output logic        rx_addr_match
);
   import eth_pkg::*;

   localparam logic [10:0] CNT_MAX   = 11'(MAX_FRAME);
   localparam logic [10:0] CNT_SAT   = 11'(MAX_FRAME + 1);
   localparam logic [10:0] CNT_MIN   = 11'(MIN_FRAME);
   localparam logic [10:0] CNT_OVH   = 11'(HDR_BYTES + FCS_BYTES);
   localparam logic [10:0] MAC_CNT   = 11'(MAC_BYTES);
   localparam logic [10:0] LAST_DEST = 11'(MAC_BYTES - 1);
   localparam logic [10:0] LAST_HDR  = 11'(HDR_BYTES - 1);
   localparam logic [2:0]  PIPE_FULL = 3'(FCS_BYTES);

   rx_state_t                   state;
   logic [10:0]                 byte_cnt;
   logic [31:0]                 crc;
   logic                        addr_ok;
   logic [FCS_BYTES-1:0][7:0]   pipe;
   logic [2:0]                  pipe_cnt;

   logic [31:0] crc_seed;
   logic [31:0] crc_next;
   logic [10:0] cnt_next;
   logic [47:0] dest_next;
   logic        addr_ok_next;
   logic        len_bad;

   // byte_cnt is the index of the byte being accepted; IDLE restarts the frame on that byte.
   always_comb begin
      crc_seed = (state == S_IDLE) ? CRC_INIT : crc;
      if (state == S_IDLE)
         cnt_next = 11'd1;
      else if (byte_cnt == CNT_SAT)
         cnt_next = CNT_SAT;
      else
         cnt_next = byte_cnt + 11'd1;
      dest_next    = {dest_mac_out[39:0], rx_data_in};
      addr_ok_next = (state == S_IDLE) ? 1'b0 : addr_ok;
      if (state == S_HDR && byte_cnt == LAST_DEST)
         addr_ok_next = (dest_next == my_mac) || (dest_next == BCAST_MAC) || promisc;
      len_bad = (cnt_next < CNT_MIN) || (cnt_next > CNT_MAX);
   end

   eth_crc32_byte #(
      .CRC_POLY (CRC_POLY)
   ) u_crc (
      .crc_in  (crc_seed),
      .data_in (rx_data_in),
      .crc_out (crc_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         byte_cnt          <= '0;
         crc               <= CRC_INIT;
         addr_ok           <= 1'b0;
         pipe              <= '0;
         pipe_cnt          <= '0;
         rx_data_out       <= '0;
         rx_data_out_valid <= 1'b0;
         dest_mac_out      <= '0;
         src_mac_out       <= '0;
         rx_payload_len    <= '0;
         rx_done           <= 1'b0;
         rx_crc_err        <= 1'b0;
         rx_len_err        <= 1'b0;
         rx_addr_match     <= 1'b0;
      end else begin
         rx_done           <= 1'b0;
         rx_data_out_valid <= 1'b0;
         if (rx_data_valid) begin
            byte_cnt <= cnt_next;
            crc      <= crc_next;
            addr_ok  <= addr_ok_next;
            case (state)
               S_IDLE: begin
                  dest_mac_out <= dest_next;
                  pipe_cnt     <= '0;
                  state        <= S_HDR;
               end
               S_HDR: begin
                  if (byte_cnt < MAC_CNT)
                     dest_mac_out <= dest_next;
                  else
                     src_mac_out <= {src_mac_out[39:0], rx_data_in};
                  if (byte_cnt == LAST_HDR)
                     state <= S_PAYLOAD;
               end
               S_PAYLOAD: begin
                  if (cnt_next > CNT_MAX) begin
                     state <= S_DROP;
                  end else begin
                     // The last four bytes held here are the FCS once rx_last arrives.
                     pipe <= {pipe[FCS_BYTES-2:0], rx_data_in};
                     if (pipe_cnt == PIPE_FULL) begin
                        rx_data_out       <= pipe[FCS_BYTES-1];
                        rx_data_out_valid <= addr_ok;
                     end else begin
                        pipe_cnt <= pipe_cnt + 3'd1;
                     end
                  end
               end
               default: begin
               end
            endcase
            if (rx_last) begin
               state          <= S_IDLE;
               rx_done        <= 1'b1;
               rx_crc_err     <= (crc_next != 32'h0);
               rx_len_err     <= len_bad;
               rx_addr_match  <= addr_ok_next;
               rx_payload_len <= len_bad ? 11'd0 : (cnt_next - CNT_OVH);
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_ethernet_rx.sv
//------------------------------------------------------------------------------
// tb_ethernet_rx -- directed scoreboard bench for ethernet_rx. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ethernet_rx;

   localparam logic [47:0] MY_MAC  = 48'h02_00_00_00_00_01;
   localparam logic [47:0] SRC_MAC = 48'h02_00_00_00_00_02;
   localparam logic [47:0] OTHER   = 48'h02_00_00_00_00_09;
   localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
   localparam logic [31:0] POLY    = 32'h04C11DB7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data_in = 8'h00;
   logic        rx_data_valid = 1'b0;
   logic        rx_last = 1'b0;
   logic [47:0] my_mac = MY_MAC;
   logic        promisc = 1'b0;
   logic [7:0]  rx_data_out;
   logic        rx_data_out_valid;
   logic [47:0] dest_mac_out;
   logic [47:0] src_mac_out;
   logic [10:0] rx_payload_len;
   logic        rx_done;
   logic        rx_crc_err;
   logic        rx_len_err;
   logic        rx_addr_match;

   typedef struct {
      logic        crc_err;
      logic        len_err;
      logic        addr_match;
      logic        chk_mac;
      logic [10:0] plen;
      logic [47:0] dst;
      logic [47:0] src;
   } status_t;

   logic [7:0] frm[$];
   logic [7:0] exp_bytes[$];
   status_t    exp_st[$];
   status_t    got_st;
   int         n_cmp = 0;
   int         n_err = 0;

   always #5 clk = ~clk;

   ethernet_rx dut (
      .clk               (clk),
      .rst               (rst),
      .rx_data_in        (rx_data_in),
      .rx_data_valid     (rx_data_valid),
      .rx_last           (rx_last),
      .my_mac            (my_mac),
      .promisc           (promisc),
      .rx_data_out       (rx_data_out),
      .rx_data_out_valid (rx_data_out_valid),
      .dest_mac_out      (dest_mac_out),
      .src_mac_out       (src_mac_out),
      .rx_payload_len    (rx_payload_len),
      .rx_done           (rx_done),
      .rx_crc_err        (rx_crc_err),
      .rx_len_err        (rx_len_err),
      .rx_addr_match     (rx_addr_match)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bit-serial reference CRC over frm[0 .. upto-1].
   function automatic logic [31:0] ref_crc(input int upto);
      logic [31:0] c;
      logic        fb;
      c = 32'hFFFF_FFFF;
      for (int i = 0; i < upto; i++) begin
         for (int b = 7; b >= 0; b--) begin
            fb = c[31] ^ frm[i][b];
            c  = {c[30:0], 1'b0};
            if (fb) c = c ^ POLY;
         end
      end
      return c;
   endfunction

   task automatic build_frame(input logic [47:0] dst, input logic [47:0] src, input int plen);
      logic [31:0] fcs;
      frm.delete();
      for (int i = 5; i >= 0; i--) frm.push_back(dst[i*8 +: 8]);
      for (int i = 5; i >= 0; i--) frm.push_back(src[i*8 +: 8]);
      for (int i = 0; i < plen; i++) frm.push_back(8'(i));
      fcs = ref_crc(frm.size());
      for (int i = 3; i >= 0; i--) frm.push_back(fcs[i*8 +: 8]);
   endtask

   task automatic expect_frame();
      status_t s;
      int      n;
      int      lim;
      logic [47:0] d;
      logic [47:0] sr;
      n  = frm.size();
      d  = '0;
      sr = '0;
      for (int i = 0; i < 6 && i < n; i++) d = {d[39:0], frm[i]};
      for (int i = 6; i < 12 && i < n; i++) sr = {sr[39:0], frm[i]};
      s.addr_match = (n >= 6) && ((d == my_mac) || (d == BCAST) || promisc);
      s.len_err    = (n < 16) || (n > 1518);
      s.plen       = s.len_err ? 11'd0 : 11'(n - 16);
      s.crc_err    = (ref_crc(n) != 32'h0);
      s.chk_mac    = (n >= 12);
      s.dst        = d;
      s.src        = sr;
      exp_st.push_back(s);
      // frm[k] leaves the FCS pipe when byte k+4 is accepted as payload.
      lim = (n - 1 < 1517) ? n - 1 : 1517;
      if (s.addr_match)
         for (int k = 12; k + 4 <= lim; k++) exp_bytes.push_back(frm[k]);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      rx_data_in    = b;
      rx_data_valid = 1'b1;
      rx_last       = last;
      @(posedge clk);
      #1;
      rx_data_valid = 1'b0;
      rx_last       = 1'b0;
   endtask

   task automatic drive_frame(input int gap_pct);
      for (int i = 0; i < frm.size(); i++) begin
         send_byte(frm[i], logic'(i == frm.size() - 1));
         if (i != frm.size() - 1 && int'($urandom_range(99)) < gap_pct) begin
            rx_data_in = 8'($urandom);
            rx_last    = 1'($urandom);
            idle(int'($urandom_range(1, 3)));
            rx_last    = 1'b0;
         end
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_data_out_valid) begin
            check("spurious_byte", 64'(exp_bytes.size() != 0), 64'(1));
            if (exp_bytes.size() != 0)
               check("payload_byte", 64'(rx_data_out), 64'(exp_bytes.pop_front()));
         end
         if (rx_done) begin
            check("spurious_done", 64'(exp_st.size() != 0), 64'(1));
            if (exp_st.size() != 0) begin
               got_st = exp_st.pop_front();
               check("crc_err", 64'(rx_crc_err), 64'(got_st.crc_err));
               check("len_err", 64'(rx_len_err), 64'(got_st.len_err));
               check("addr_match", 64'(rx_addr_match), 64'(got_st.addr_match));
               check("payload_len", 64'(rx_payload_len), 64'(got_st.plen));
               if (got_st.chk_mac) begin
                  check("dest_mac", 64'(dest_mac_out), 64'(got_st.dst));
                  check("src_mac", 64'(src_mac_out), 64'(got_st.src));
               end
            end
         end
      end
   end

   initial begin
      rst = 1'b1;
      #1;
      check("rst_out_valid", 64'(rx_data_out_valid), 64'(0));
      check("rst_data_out", 64'(rx_data_out), 64'(0));
      check("rst_done", 64'(rx_done), 64'(0));
      check("rst_dest", 64'(dest_mac_out), 64'(0));
      check("rst_src", 64'(src_mac_out), 64'(0));
      check("rst_plen", 64'(rx_payload_len), 64'(0));
      check("rst_crc_err", 64'(rx_crc_err), 64'(0));
      check("rst_len_err", 64'(rx_len_err), 64'(0));
      check("rst_addr_match", 64'(rx_addr_match), 64'(0));
      idle(3);
      rst = 1'b0;
      idle(2);

      // Good unicast, 46-byte payload
      build_frame(MY_MAC, SRC_MAC, 46);
      expect_frame();
      drive_frame(0);
      idle(4);

      // Payload byte 10 bit 0 flipped
      build_frame(MY_MAC, SRC_MAC, 46);
      frm[22] = frm[22] ^ 8'h01;
      expect_frame();
      drive_frame(0);
      idle(4);

      // Broadcast, then foreign address without and with promiscuous mode
      build_frame(BCAST, SRC_MAC, 46);
      expect_frame();
      drive_frame(0);
      idle(4);
      build_frame(OTHER, SRC_MAC, 46);
      expect_frame();
      drive_frame(0);
      idle(4);
      promisc = 1'b1;
      build_frame(OTHER, SRC_MAC, 46);
      expect_frame();
      drive_frame(0);
      idle(4);
      promisc = 1'b0;

      // 10-byte runt
      build_frame(MY_MAC, SRC_MAC, 46);
      while (frm.size() > 10) void'(frm.pop_back());
      expect_frame();
      drive_frame(0);
      idle(4);

      // 1600-byte oversize frame
      build_frame(MY_MAC, SRC_MAC, 1584);
      expect_frame();
      drive_frame(0);
      idle(4);

      // Back-to-back, gaps inside the first
      build_frame(MY_MAC, SRC_MAC, 60);
      expect_frame();
      drive_frame(40);
      build_frame(BCAST, 48'h0A_0B_0C_0D_0E_0F, 50);
      expect_frame();
      drive_frame(0);
      idle(4);

      // Reset at byte 20: only frm[12..15] have left the pipe by then
      build_frame(MY_MAC, SRC_MAC, 46);
      for (int k = 12; k <= 15; k++) exp_bytes.push_back(frm[k]);
      for (int i = 0; i < 20; i++) send_byte(frm[i], 1'b0);
      @(negedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_out_valid", 64'(rx_data_out_valid), 64'(0));
      check("abort_dest", 64'(dest_mac_out), 64'(0));
      check("abort_src", 64'(src_mac_out), 64'(0));
      check("abort_plen", 64'(rx_payload_len), 64'(0));
      check("abort_addr_match", 64'(rx_addr_match), 64'(0));
      check("abort_done", 64'(rx_done), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Good 64-byte frame after the abort
      build_frame(MY_MAC, SRC_MAC, 48);
      expect_frame();
      drive_frame(0);
      idle(10);

      check("bytes_outstanding", 64'(exp_bytes.size()), 64'(0));
      check("status_outstanding", 64'(exp_st.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
